// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush controller for the five-stage core pipeline. It is the
// only source of the stall/clear controls of the inter-stage registers and of
// the PC hold. It resolves load-use hazards, taken-branch flushes, data-memory
// wait states and a debug halt/drain sequence.
//
// All control outputs are combinational (Mealy) functions of the registered
// FSM state and the current inputs, so they act in the same cycle.
//
// Parameters:
//   DRAIN_CYCLES      cycles spent in DRAIN before HALTED (legal 1..7)
//
// Ports:
//   clk               core clock, rising edge
//   rst_n             asynchronous active-low reset
//   id_rs1_addr_i     rs1 of the instruction in ID
//   id_rs2_addr_i     rs2 of the instruction in ID
//   id_uses_rs1_i     ID instruction reads rs1
//   id_uses_rs2_i     ID instruction reads rs2
//   ex_rd_addr_i      rd of the instruction in EX
//   ex_mem_read_i     EX instruction is a load
//   ex_branch_taken_i EX resolved a taken branch/jump
//   lsu_busy_i        data memory has not completed the MEM-stage access
//   halt_req_i        debug halt request (level)
//   pc_stall_o        hold PC
//   if_id_stall_o     IF/ID register hold
//   if_id_clear_o     IF/ID register load no-op
//   id_ex_stall_o     ID/EX register hold
//   id_ex_clear_o     ID/EX register load no-op
//   ex_mem_stall_o    EX/MEM register hold
//   halted_o          core halted, pipeline empty
//
// Optional feature (macro PIPE_CTRL_PERF_EN):
//   stall_cycles_o    32-bit count of RUN cycles with pc_stall_o=1
//   flush_count_o     32-bit count of accepted branch flushes
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_branch_taken_i,
  input  logic        lsu_busy_i,
  input  logic        halt_req_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        if_id_clear_o,
  output logic        id_ex_stall_o,
  output logic        id_ex_clear_o,
  output logic        ex_mem_stall_o,
  output logic        halted_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
`endif
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Counter value on which the last drain cycle is spent.
  localparam logic [2:0] DRAIN_LAST_C = 3'(DRAIN_CYCLES - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] drain_cnt_r;
  logic [2:0] drain_cnt_nxt_s;
  logic       load_use_s;
  logic       flush_accept_s;

  // A load in EX whose destination is read by the instruction in ID. x0 never
  // creates a dependency because it is hard-wired to zero.
  assign load_use_s = ex_mem_read_i
                    & (ex_rd_addr_i != 5'd0)
                    & ((id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i))
                     | (id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i)));

  // State and drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      drain_cnt_r <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  // Next-state and drain counter logic. A busy data memory freezes both.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    case (state_r)
      ST_INIT: begin
        // INIT lasts exactly one cycle, independent of every other input.
        state_nxt_s     = ST_RUN;
        drain_cnt_nxt_s = 3'd0;
      end
      ST_RUN: begin
        if (halt_req_i && !lsu_busy_i) begin
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s     = ST_RUN;
          drain_cnt_nxt_s = drain_cnt_r;
        end
      end
      ST_DRAIN: begin
        // Once started, the drain completes even if halt_req_i drops.
        if (lsu_busy_i) begin
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = drain_cnt_r;
        end else if (drain_cnt_r == DRAIN_LAST_C) begin
          state_nxt_s     = ST_HALTED;
          drain_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = drain_cnt_r + 3'd1;
        end
      end
      ST_HALTED: begin
        if (!halt_req_i && !lsu_busy_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
      default: begin
        state_nxt_s     = ST_INIT;
        drain_cnt_nxt_s = 3'd0;
      end
    endcase
  end

  // Mealy control outputs. Priority: INIT, busy freeze, branch flush,
  // DRAIN/HALTED rules, load-use bubble.
  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_clear_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_clear_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    halted_o       = 1'b0;
    flush_accept_s = 1'b0;
    case (state_r)
      ST_RUN, ST_DRAIN, ST_HALTED: begin
        halted_o = (state_r == ST_HALTED);
        if (lsu_busy_i) begin
          // Whole pipeline frozen; a taken branch simply stays in EX and is
          // flushed on the first non-busy cycle.
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_stall_o  = 1'b1;
          ex_mem_stall_o = 1'b1;
        end else if (ex_branch_taken_i) begin
          // PC loads the target while both younger stages become bubbles.
          if_id_clear_o  = 1'b1;
          id_ex_clear_o  = 1'b1;
          flush_accept_s = 1'b1;
        end else begin
          case (state_r)
            ST_DRAIN: begin
              pc_stall_o    = 1'b1;
              if_id_clear_o = 1'b1;
            end
            ST_HALTED: begin
              pc_stall_o     = 1'b1;
              if_id_stall_o  = 1'b1;
              id_ex_stall_o  = 1'b1;
              ex_mem_stall_o = 1'b1;
            end
            ST_RUN: begin
              if (load_use_s) begin
                // One bubble into EX; forwarding resolves the retried cycle.
                pc_stall_o    = 1'b1;
                if_id_stall_o = 1'b1;
                id_ex_clear_o = 1'b1;
              end else begin
                pc_stall_o    = 1'b0;
              end
            end
            default: begin
              pc_stall_o = 1'b0;
            end
          endcase
        end
      end
      default: begin
        // INIT: load no-ops into IF/ID and ID/EX.
        if_id_clear_o = 1'b1;
        id_ex_clear_o = 1'b1;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_count_r;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= 32'd0;
      flush_count_r  <= 32'd0;
    end else begin
      if ((state_r == ST_RUN) && pc_stall_o) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
      if (flush_accept_s) begin
        flush_count_r <= flush_count_r + 32'd1;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_r;
  assign flush_count_o  = flush_count_r;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1_addr_i;
  logic [4:0] id_rs2_addr_i;
  logic       id_uses_rs1_i;
  logic       id_uses_rs2_i;
  logic [4:0] ex_rd_addr_i;
  logic       ex_mem_read_i;
  logic       ex_branch_taken_i;
  logic       lsu_busy_i;
  logic       halt_req_i;
  logic       pc_stall_o;
  logic       if_id_stall_o;
  logic       if_id_clear_o;
  logic       id_ex_stall_o;
  logic       id_ex_clear_o;
  logic       ex_mem_stall_o;
  logic       halted_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Output vector order: pc_stall, if_id_stall, if_id_clear, id_ex_stall,
  // id_ex_clear, ex_mem_stall, halted.
  localparam logic [6:0] O_INIT   = 7'b0010100;
  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_LDUSE  = 7'b1100100;
  localparam logic [6:0] O_FLUSH  = 7'b0010100;
  localparam logic [6:0] O_BUSY   = 7'b1101010;
  localparam logic [6:0] O_DRAIN  = 7'b1010000;
  localparam logic [6:0] O_HALTED = 7'b1101011;

  pipeline_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1_addr_i     (id_rs1_addr_i),
    .id_rs2_addr_i     (id_rs2_addr_i),
    .id_uses_rs1_i     (id_uses_rs1_i),
    .id_uses_rs2_i     (id_uses_rs2_i),
    .ex_rd_addr_i      (ex_rd_addr_i),
    .ex_mem_read_i     (ex_mem_read_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .lsu_busy_i        (lsu_busy_i),
    .halt_req_i        (halt_req_i),
    .pc_stall_o        (pc_stall_o),
    .if_id_stall_o     (if_id_stall_o),
    .if_id_clear_o     (if_id_clear_o),
    .id_ex_stall_o     (id_ex_stall_o),
    .id_ex_clear_o     (id_ex_clear_o),
    .ex_mem_stall_o    (ex_mem_stall_o),
    .halted_o          (halted_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles_o    (stall_cycles_o),
    .flush_count_o     (flush_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {pc_stall_o, if_id_stall_o, if_id_clear_o, id_ex_stall_o,
            id_ex_clear_o, ex_mem_stall_o, halted_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1_addr_i     = 5'd0;
    id_rs2_addr_i     = 5'd0;
    id_uses_rs1_i     = 1'b0;
    id_uses_rs2_i     = 1'b0;
    ex_rd_addr_i      = 5'd0;
    ex_mem_read_i     = 1'b0;
    ex_branch_taken_i = 1'b0;
    lsu_busy_i        = 1'b0;
    halt_req_i        = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("reset_hold", 32'(outs()), 32'(O_INIT));
    end
    step(); rst_n = 1'b1; #1;
    chk("init_after_release", 32'(outs()), 32'(O_INIT));
    step(); #1;
    chk("run_idle", 32'(outs()), 32'(O_IDLE));

    // Load-use through rs2.
    step(); ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd5;
    id_rs2_addr_i = 5'd5; id_uses_rs2_i = 1'b1; #1;
    chk("load_use_rs2", 32'(outs()), 32'(O_LDUSE));
    step(); ex_mem_read_i = 1'b0; #1;
    chk("after_bubble", 32'(outs()), 32'(O_IDLE));
    // rd = x0 never hazards.
    step(); ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0; #1;
    chk("load_use_x0", 32'(outs()), 32'(O_IDLE));
    // Load-use through rs1.
    step(); idle_inputs(); ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd7;
    id_rs1_addr_i = 5'd7; id_uses_rs1_i = 1'b1; #1;
    chk("load_use_rs1", 32'(outs()), 32'(O_LDUSE));
    // Matching rs1 that is not read: no hazard.
    step(); id_uses_rs1_i = 1'b0; #1;
    chk("load_use_unused_rs1", 32'(outs()), 32'(O_IDLE));
    // Not a load: no hazard.
    step(); id_uses_rs1_i = 1'b1; ex_mem_read_i = 1'b0; #1;
    chk("no_load_no_hazard", 32'(outs()), 32'(O_IDLE));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_cycles", stall_cycles_o, 32'd2);
    chk("perf_flush_before", flush_count_o, 32'd0);
`endif

    // Branch together with load-use: flush wins, PC not held.
    step(); ex_mem_read_i = 1'b1; ex_branch_taken_i = 1'b1; #1;
    chk("branch_over_load_use", 32'(outs()), 32'(O_FLUSH));
    step(); idle_inputs(); #1;
    chk("after_branch", 32'(outs()), 32'(O_IDLE));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_flush_after", flush_count_o, 32'd1);
`endif

    // Busy for four cycles with a pending branch, flush on the fifth.
    for (int i = 0; i < 4; i++) begin
      step(); lsu_busy_i = 1'b1; ex_branch_taken_i = 1'b1; #1;
      chk("busy_freeze", 32'(outs()), 32'(O_BUSY));
    end
    step(); lsu_busy_i = 1'b0; #1;
    chk("deferred_flush", 32'(outs()), 32'(O_FLUSH));
    step(); idle_inputs(); #1;
    chk("after_deferred_flush", 32'(outs()), 32'(O_IDLE));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_flush_deferred", flush_count_o, 32'd2);
`endif
    // Busy overrides a load-use hazard.
    step(); lsu_busy_i = 1'b1; ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd9;
    id_rs1_addr_i = 5'd9; id_uses_rs1_i = 1'b1; #1;
    chk("busy_over_load_use", 32'(outs()), 32'(O_BUSY));

    // Halt: request in RUN (cycle N), DRAIN N+1..N+3, HALTED N+4.
    step(); idle_inputs(); halt_req_i = 1'b1; #1;
    chk("halt_req_run", 32'(outs()), 32'(O_IDLE));
    step(); ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd3;
    id_rs2_addr_i = 5'd3; id_uses_rs2_i = 1'b1; #1;
    chk("drain_1_no_load_use", 32'(outs()), 32'(O_DRAIN));
    step(); idle_inputs(); ex_branch_taken_i = 1'b1; #1;
    chk("drain_2_branch", 32'(outs()), 32'(O_FLUSH));
    step(); idle_inputs(); #1;
    chk("drain_3_no_abort", 32'(outs()), 32'(O_DRAIN));
    step(); halt_req_i = 1'b1; #1;
    chk("halted", 32'(outs()), 32'(O_HALTED));
    step(); lsu_busy_i = 1'b1; halt_req_i = 1'b0; #1;
    chk("halted_busy_hold", 32'(outs()), 32'(O_HALTED));
    step(); lsu_busy_i = 1'b0; #1;
    chk("halted_release", 32'(outs()), 32'(O_HALTED));
    step(); #1;
    chk("resume_run", 32'(outs()), 32'(O_IDLE));

    // Halt again, then asynchronous reset while HALTED.
    step(); halt_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("drain_again", 32'(outs()), 32'(O_DRAIN));
    end
    step(); #1;
    chk("halted_again", 32'(outs()), 32'(O_HALTED));
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", 32'(outs()), 32'(O_INIT));
    step(); #1;
    chk("async_reset_hold", 32'(outs()), 32'(O_INIT));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_cleared", stall_cycles_o, 32'd0);
    chk("perf_flush_cleared", flush_count_o, 32'd0);
`endif
    step(); rst_n = 1'b1; halt_req_i = 1'b0; #1;
    chk("async_init_after_release", 32'(outs()), 32'(O_INIT));
    step(); #1;
    chk("async_back_to_run", 32'(outs()), 32'(O_IDLE));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage core pipeline. It drives the `stall_ctrl`/`clear_ctrl` pair of every inter-stage register and the PC hold. It resolves load-use hazards, taken-branch flushes, data-memory wait states and a debug halt/drain sequence. The block sits beside the datapath in the core top and is the only source of pipeline-register control.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED (ID, EX and MEM emptied); legal range 1..7

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1_addr_i  in  5  rs1 of instruction in ID
- id_rs2_addr_i  in  5  rs2 of instruction in ID
- id_uses_rs1_i  in  1  ID instruction reads rs1
- id_uses_rs2_i  in  1  ID instruction reads rs2
- ex_rd_addr_i  in  5  rd of instruction in EX
- ex_mem_read_i  in  1  EX instruction is a load
- ex_branch_taken_i  in  1  EX resolved a taken branch/jump
- lsu_busy_i  in  1  data memory has not completed the MEM-stage access
- halt_req_i  in  1  debug halt request, level
- pc_stall_o  out  1  hold PC
- if_id_stall_o / if_id_clear_o  out  1 each  IF/ID register control
- id_ex_stall_o / id_ex_clear_o  out  1 each  ID/EX register control
- ex_mem_stall_o  out  1  EX/MEM register hold
- halted_o  out  1  core halted, pipeline empty

## Operation
- Registered state: FSM {INIT, RUN, DRAIN, HALTED}, 3-bit drain counter. All control outputs are combinational from state and inputs (Mealy).
- Reset drives state INIT and counter 0. Output values in INIT:
  - if_id_clear_o=1, id_ex_clear_o=1.
  - All stalls 0, halted_o=0.
- INIT -> RUN unconditionally after one cycle. The first edge after reset loads no-ops into IF/ID and ID/EX.
- Load-use hazard (RUN only): hazard = ex_mem_read_i & ex_rd_addr_i!=0 & ((id_uses_rs1_i & rs1==rd) | (id_uses_rs2_i & rs2==rd)).
  - Response: pc_stall_o=1, if_id_stall_o=1, id_ex_clear_o=1.
  - Exactly one bubble is inserted; forwarding covers the next cycle.
- Taken branch: if_id_clear_o=1 and id_ex_clear_o=1. pc_stall_o=0 so the PC loads the target. This overrides load-use; the stall is suppressed.
- lsu_busy_i=1 freezes the whole pipeline in any state:
  - pc_stall_o, if_id_stall_o, id_ex_stall_o and ex_mem_stall_o all 1; all clears 0.
  - A pending branch flush is deferred until the first cycle with lsu_busy_i=0.
  - The FSM state and drain counter hold.
- Priority, high to low: INIT > lsu_busy > branch > DRAIN/HALTED rules > load-use.
- RUN -> DRAIN when halt_req_i=1 and lsu_busy_i=0. The counter loads 0.
- DRAIN behaviour:
  - pc_stall_o=1 and if_id_clear_o=1, so no new instructions enter.
  - The counter increments each non-busy cycle.
  - At counter==DRAIN_CYCLES-1 the next state is HALTED.
  - A branch taken during DRAIN still flushes (no-ops only).
  - halt_req_i deasserting during DRAIN does not abort the drain.
- HALTED behaviour:
  - halted_o=1.
  - pc_stall_o, if_id_stall_o, id_ex_stall_o and ex_mem_stall_o all 1.
  - HALTED -> RUN when halt_req_i=0. Fetch resumes at the held PC; halted_o=0 in RUN.
- Load-use detection is disabled outside RUN.

## Timing
- Control outputs respond in the same cycle as the inputs (zero latency).
- Register effects of a clear asserted in cycle N:
  - No-op flag visible at the register output in N+1.
  - A held register shows the same value in N+1.
- Load-use costs 1 cycle. A branch costs 2 bubbles. lsu_busy costs 1 cycle per busy cycle.
- Halt latency: halt_req_i in RUN at cycle N (not busy) gives halted_o=1 at cycle N+DRAIN_CYCLES+1 (N+4 by default), plus any busy cycles.
- Asynchronous reset mid-operation:
  - The FSM returns to INIT immediately.
  - Outputs take INIT values while rst_n=0 and for one cycle after release.
  - Perf counters clear.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds 32-bit outputs stall_cycles_o and flush_count_o.
  - stall_cycles_o increments each cycle pc_stall_o=1 in RUN.
  - flush_count_o increments each cycle with an accepted branch flush.
  - Both wrap at 2^32 and reset to 0.
- PIPE_CTRL_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset: rst_n low 3 cycles then high -> during reset and the first cycle after, if_id_clear_o=1, id_ex_clear_o=1, all stalls 0; second cycle all outputs 0.
- Load-use: ex_mem_read_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, id_uses_rs2_i=1 -> pc_stall_o=if_id_stall_o=id_ex_clear_o=1 for one cycle.
  - Repeat with ex_rd_addr_i=0 -> no stall.
- Branch + load-use in the same cycle -> if_id_clear_o=id_ex_clear_o=1, pc_stall_o=0. (with perf enabled) flush_count_o 0->1.
- lsu_busy_i high 4 cycles with ex_branch_taken_i=1 -> 4 cycles of all four stalls and no clears; flush asserted in cycle 5.
- Halt: halt_req_i=1 in RUN at cycle 10 -> DRAIN cycles 11-13 with pc_stall_o=if_id_clear_o=1; halted_o=1 at cycle 14; halt_req_i=0 at 20 -> halted_o=0 and stalls 0 at 21.
- Async reset asserted while HALTED -> halted_o=0 immediately; INIT outputs; returns to RUN one cycle after release.
